// File: rtl/ovl_win_sched_pkg.sv
// ovl_win_sched_pkg
//   Shared types and helpers for the OVL window scheduler and its arbiter.
//   - win_state_t : scheduler FSM states
//   - STATE_W     : encoded state width
//   - next_ptr()  : round-robin pointer advance with wrap at num_req
package ovl_win_sched_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    START  = 3'd2,
    OPEN   = 3'd3,
    END    = 3'd4,
    REPORT = 3'd5
  } win_state_t;

  function automatic int unsigned next_ptr(input int unsigned ptr,
                                           input int unsigned num_req);
    if (ptr + 1 >= num_req) begin
      return 0;
    end
    return ptr + 1;
  endfunction

endpackage

// File: rtl/ovl_rr_arb.sv
// ovl_rr_arb
//   Combinational round-robin pick: the first set request at or after the
//   pointer, wrapping past NUM_REQ-1 back to 0.
//   Ports:
//     req_i  [NUM_REQ]       request vector
//     ptr_i  [clog2(NUM_REQ)] search start position (must be < NUM_REQ)
//     gnt_o  [NUM_REQ]       one-hot pick, 0 when no request
//     idx_o  [clog2(NUM_REQ)] index of the pick, 0 when no request
//     vld_o                  at least one request present
module ovl_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       vld_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr + i stays below 2*NUM_REQ, so one conditional subtract wraps it.
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      pos = sum[IDX_W-1:0];
      if (!vld_o && req_i[pos]) begin
        vld_o      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/ovl_win_sched.sv
// ovl_win_sched
//   Time-shares one ovl_win_unchange checker among NUM_REQ requesters. A
//   round-robin winner gets a window: its data is driven onto test_expr, the
//   checker is framed with start_event / end_event around win_len OPEN
//   cycles, and the checker's fire output is folded into a per-requester
//   pass/fail result pulsed on done/fail.
//   Ports:
//     clock        sole clock, posedge
//     reset        asynchronous active-low reset
//     enable       gates new grants only
//     req          level request per requester
//     win_len      per-requester window length, sampled at grant
//     data         per-requester observed value
//     fire_in      checker fire (bit 0)
//     gnt          one-hot grant, GRANT..REPORT
//     busy         high outside IDLE
//     start_event  checker window start pulse
//     end_event    checker window end pulse
//     test_expr    granted data (registered), 0 in IDLE/REPORT
//     done         one-cycle completion pulse on the granted bit
//     fail         valid with done, 1 = checker fired during the window
module ovl_win_sched
  import ovl_win_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int LEN_W   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] win_len,
  input  logic [NUM_REQ*WIDTH-1:0] data,
  input  logic                     fire_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic                     start_event,
  output logic                     end_event,
  output logic [WIDTH-1:0]         test_expr,
  output logic [NUM_REQ-1:0]       done,
  output logic [NUM_REQ-1:0]       fail
);

  localparam int IDX_W = $clog2(NUM_REQ);

  win_state_t         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               flat_q, flat_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic               end_q, end_d;
  logic [WIDTH-1:0]   texp_q, texp_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] fail_q, fail_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;

  logic [WIDTH-1:0]   data_a [NUM_REQ];
  logic [LEN_W-1:0]   len_a  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_a[i] = data[i*WIDTH +: WIDTH];
    assign len_a[i]  = win_len[i*LEN_W +: LEN_W];
  end

  ovl_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    flat_d  = flat_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    fail_d  = '0;

    case (state_q)
      IDLE: begin
        if (enable && arb_vld) begin
          state_d = GRANT;
          idx_d   = arb_idx;
          gnt_d   = arb_gnt;
          cnt_d   = len_a[arb_idx];
          flat_d  = 1'b0;
        end
      end
      GRANT: begin
        state_d = START;
      end
      START: begin
        flat_d  = flat_q | fire_in;
        state_d = (cnt_q == '0) ? END : OPEN;
      end
      OPEN: begin
        flat_d = flat_q | fire_in;
        cnt_d  = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = END;
        end
      end
      END: begin
        // Fire seen on this same edge still counts: the checker's fire is
        // registered, so its verdict on the last OPEN cycle lands here.
        flat_d  = flat_q | fire_in;
        done_d  = gnt_q;
        fail_d  = (flat_q | fire_in) ? gnt_q : '0;
        state_d = REPORT;
      end
      REPORT: begin
        ptr_d   = IDX_W'(next_ptr(32'(idx_q), NUM_REQ));
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so each pulse lines up
    // with the state it belongs to.
    start_d = (state_d == START);
    end_d   = (state_d == END);
    busy_d  = (state_d != IDLE);
    texp_d  = ((state_d != IDLE) && (state_d != REPORT)) ? data_a[idx_d] : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      flat_q  <= 1'b0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      texp_q  <= '0;
      done_q  <= '0;
      fail_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      flat_q  <= flat_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      end_q   <= end_d;
      texp_q  <= texp_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign gnt         = gnt_q;
  assign busy        = busy_q;
  assign start_event = start_q;
  assign end_event   = end_q;
  assign test_expr   = texp_q;
  assign done        = done_q;
  assign fail        = fail_q;

endmodule
